// File: rtl/alu_issue_stage.sv
// Operand/issue stage for the 16-bit ALU: 8-entry register file, registered ALU operands, writeback.
// Optional macro ALU_FWD_EN: bypass alu_out into hazarded operands instead of interlocking.
module alu_issue_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [SEL_W-1:0]  instr_sel,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic              instr_use_imm,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    output logic [SEL_W-1:0]  alu_select,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREGS];
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;

    logic [DATA_W-1:0] opa_c;
    logic [DATA_W-1:0] opb_c;
    logic              hazard_c;
    logic              issue_c;

    // Operand selection; r0 is never written so reading it always yields zero.
    always_comb begin
        opa_c    = regs[instr_rs1];
        opb_c    = instr_use_imm ? instr_imm : regs[instr_rs2];
        hazard_c = 1'b0;
`ifdef ALU_FWD_EN
        if (ex_valid && (ex_rd != '0)) begin
            if (ex_rd == instr_rs1) begin
                opa_c = alu_out;
            end
            if (!instr_use_imm && (ex_rd == instr_rs2)) begin
                opb_c = alu_out;
            end
        end
`else
        hazard_c = ex_valid && (ex_rd != '0) &&
                   ((ex_rd == instr_rs1) || (!instr_use_imm && (ex_rd == instr_rs2)));
`endif
    end

    assign instr_ready = rst_n && !hazard_c;
    assign issue_c     = instr_valid && instr_ready;
    assign dbg_data    = regs[dbg_addr];

    // Issue register, execute tracking and writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            alu_in0    <= '0;
            alu_in1    <= '0;
            alu_select <= '0;
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            if (issue_c) begin
                alu_in0    <= opa_c;
                alu_in1    <= opb_c;
                alu_select <= instr_sel;
                ex_rd      <= instr_rd;
                ex_valid   <= 1'b1;
            end else begin
                ex_valid   <= 1'b0;
            end

            if (ex_valid) begin
                if (ex_rd != '0) begin
                    regs[ex_rd] <= alu_out;
                end
                wb_valid <= 1'b1;
                wb_rd    <= ex_rd;
                wb_data  <= alu_out;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; includes a small ALU model driving alu_out.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_sel;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic        instr_use_imm;
    logic [15:0] instr_imm;
    logic [15:0] alu_in0;
    logic [15:0] alu_in1;
    logic [3:0]  alu_select;
    logic [15:0] alu_out;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] wbq_data [$];
    logic [2:0]  wbq_rd [$];

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_sel(instr_sel), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_select(alu_select),
        .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: 1 pass B, 2 add, 3 sub, 4 mul, 5 div; codes >= 11 give zero.
    always_comb begin
        case (alu_select)
            4'd0:    alu_out = alu_in0 & alu_in1;
            4'd1:    alu_out = alu_in1;
            4'd2:    alu_out = alu_in0 + alu_in1;
            4'd3:    alu_out = alu_in0 - alu_in1;
            4'd4:    alu_out = 16'(alu_in0 * alu_in1);
            4'd5:    alu_out = (alu_in1 == 16'd0) ? 16'hFFFF : alu_in0 / alu_in1;
            4'd6:    alu_out = alu_in0 | alu_in1;
            4'd7:    alu_out = alu_in0 ^ alu_in1;
            default: alu_out = 16'd0;
        endcase
    end

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            wbq_data.push_back(wb_data);
            wbq_rd.push_back(wb_rd);
        end
    end

    // Presents one instruction, waits (bounded) for ready, and returns after the issuing edge.
    task automatic issue(input logic [3:0] sel, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm,
                         output int stalls);
        stalls = 0;
        @(negedge clk);
        instr_sel = sel; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_use_imm = use_imm; instr_imm = imm; instr_valid = 1'b1;
        #1;
        while (instr_ready !== 1'b1 && stalls < 8) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_timeout rd=%0d: ready=%b after %0d cycles, required 1", rd, instr_ready, stalls);
            instr_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready_first: got %b required 0", instr_ready);
        end
        @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready_second: got %b required 0", instr_ready);
        end
        vectors++;
        if ({alu_in0, alu_in1, alu_select} !== 36'd0) begin
            miscompares++; $display("FAIL reset_alu_regs: got %h/%h/%h required 0", alu_in0, alu_in1, alu_select);
        end
        vectors++;
        if ({wb_valid, wb_rd, wb_data} !== 20'd0) begin
            miscompares++; $display("FAIL reset_wb: got %b/%h/%h required 0", wb_valid, wb_rd, wb_data);
        end
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            vectors++;
            if (dbg_data !== 16'd0) begin
                miscompares++; $display("FAIL reset_dbg r%0d: got %h required 0000", a, dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++; $display("FAIL ready_after_reset: got %b required 1", instr_ready);
        end
    endtask

    task automatic test_load_imm();
        logic [15:0] exp_d [3];
        logic [2:0]  exp_r [3];
        logic [15:0] got_d;
        logic [2:0]  got_r;
        int st;
        exp_d = '{16'd13, 16'd6, 16'd19};
        exp_r = '{3'd1, 3'd2, 3'd3};
        wbq_data.delete(); wbq_rd.delete();
        issue(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'd13, st);
        issue(4'd1, 3'd2, 3'd0, 3'd0, 1'b1, 16'd6, st);
        issue(4'd2, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, st);
        vectors++;
        if (alu_select !== 4'd2 || alu_in0 !== 16'd13 || alu_in1 !== 16'd6) begin
            miscompares++;
            $display("FAIL add_operands: got sel=%0d in0=%0d in1=%0d required sel=2 in0=13 in1=6", alu_select, alu_in0, alu_in1);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wbq_data.size() != 3) begin
            miscompares++; $display("FAIL load_wb_count: got %0d required 3", wbq_data.size());
        end
        for (int i = 0; i < 3; i++) begin
            got_d = (i < wbq_data.size()) ? wbq_data[i] : 16'hxxxx;
            got_r = (i < wbq_rd.size()) ? wbq_rd[i] : 3'bxxx;
            vectors++;
            if (got_d !== exp_d[i] || got_r !== exp_r[i]) begin
                miscompares++;
                $display("FAIL load_wb[%0d]: got r%0d=%0d required r%0d=%0d", i, got_r, got_d, exp_r[i], exp_d[i]);
            end
        end
        dbg_addr = 3'd3;
        #1;
        vectors++;
        if (dbg_data !== 16'd19) begin
            miscompares++; $display("FAIL dbg_r3: got %0d required 19", dbg_data);
        end
    endtask

    task automatic test_r0_write();
        int st;
        wbq_data.delete(); wbq_rd.delete();
        issue(4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'hBEEF, st);
        repeat (3) @(negedge clk);
        vectors++;
        if (wbq_data.size() != 1 || wbq_data[0] !== 16'hBEEF || wbq_rd[0] !== 3'd0) begin
            miscompares++;
            $display("FAIL r0_wb: got count=%0d data=%h required count=1 data=beef rd=0",
                     wbq_data.size(), (wbq_data.size() > 0) ? wbq_data[0] : 16'hxxxx);
        end
        dbg_addr = 3'd0;
        #1;
        vectors++;
        if (dbg_data !== 16'd0) begin
            miscompares++; $display("FAIL r0_stays_zero: got %h required 0000", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        int st1, st2, exp_stall;
`ifdef ALU_FWD_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        wbq_data.delete(); wbq_rd.delete();
        issue(4'd3, 3'd4, 3'd1, 3'd2, 1'b0, 16'd0, st1);
        issue(4'd4, 3'd5, 3'd4, 3'd2, 1'b0, 16'd0, st2);
        vectors++;
        if (st1 != 0 || st2 != exp_stall) begin
            miscompares++; $display("FAIL dep_stall_cycles: got %0d,%0d required 0,%0d", st1, st2, exp_stall);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wbq_data.size() != 2 || wbq_data[0] !== 16'd7 || wbq_data[1] !== 16'd42) begin
            miscompares++;
            $display("FAIL dep_wb: got count=%0d last=%0d required 7 then 42",
                     wbq_data.size(), (wbq_data.size() > 0) ? wbq_data[wbq_data.size()-1] : 16'hxxxx);
        end
        dbg_addr = 3'd5;
        #1;
        vectors++;
        if (dbg_data !== 16'd42) begin
            miscompares++; $display("FAIL dbg_r5: got %0d required 42", dbg_data);
        end
    endtask

    task automatic test_unused_op();
        int st;
        wbq_data.delete(); wbq_rd.delete();
        issue(4'd1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0055, st);
        issue(4'd11, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0, st);
        vectors++;
        if (alu_select !== 4'd11) begin
            miscompares++; $display("FAIL unused_sel_passthru: got %0d required 11", alu_select);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wbq_data.size() != 2 || wbq_data[0] !== 16'h0055 || wbq_data[1] !== 16'd0 || wbq_rd[1] !== 3'd6) begin
            miscompares++; $display("FAIL unused_wb: got count=%0d required 0055 then 0000 to r6", wbq_data.size());
        end
        dbg_addr = 3'd6;
        #1;
        vectors++;
        if (dbg_data !== 16'd0) begin
            miscompares++; $display("FAIL dbg_r6: got %h required 0000", dbg_data);
        end
    endtask

    task automatic test_reset_midop();
        int st;
        wbq_data.delete(); wbq_rd.delete();
        issue(4'd1, 3'd7, 3'd0, 3'd0, 1'b1, 16'h1234, st);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (wbq_data.size() != 0) begin
            miscompares++; $display("FAIL midop_no_wb: got %0d pulses required 0", wbq_data.size());
        end
        dbg_addr = 3'd7;
        #1;
        vectors++;
        if (dbg_data !== 16'd0) begin
            miscompares++; $display("FAIL midop_dbg_r7: got %h required 0000", dbg_data);
        end
        dbg_addr = 3'd1;
        #1;
        vectors++;
        if (dbg_data !== 16'd0) begin
            miscompares++; $display("FAIL midop_dbg_r1: got %h required 0000", dbg_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_sel = '0; instr_rd = '0; instr_rs1 = '0;
        instr_rs2 = '0; instr_use_imm = 1'b0; instr_imm = '0; dbg_addr = '0;
        test_reset();
        test_load_imm();
        test_r0_write();
        test_back_to_back();
        test_unused_op();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream operand/issue stage for the 16-bit ALU.
- Holds an 8-entry register file and accepts one instruction per cycle over a valid/ready handshake.
- Drives registered in0/in1/select into the combinational ALU, then captures the ALU out one cycle later and writes it back to the destination register.
- Forms the execute/writeback half of the core datapath.

Parameters:
DATA_W, 16, operand/result width; matches ALU in0/in1/out
REG_AW, 3, register address width (2**REG_AW registers)
SEL_W, 4, ALU select width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  stage can accept instruction this cycle
instr_sel  in  SEL_W  ALU operation code, forwarded unchanged
instr_rd  in  REG_AW  destination register
instr_rs1  in  REG_AW  source register for in0
instr_rs2  in  REG_AW  source register for in1
instr_use_imm  in  1  1: in1 = instr_imm, 0: in1 = regs[rs2]
instr_imm  in  DATA_W  immediate operand
alu_in0  out  DATA_W  registered operand A to ALU in0
alu_in1  out  DATA_W  registered operand B to ALU in1
alu_select  out  SEL_W  registered op code to ALU select
alu_out  in  DATA_W  ALU combinational result
wb_valid  out  1  one-cycle pulse: writeback occurred
wb_rd  out  REG_AW  register written
wb_data  out  DATA_W  value written
dbg_addr  in  REG_AW  debug read address
dbg_data  out  DATA_W  regs[dbg_addr], combinational

Behaviour:
- Clock and reset: single clock clk; reset rst_n synchronous, active-low. No other reset path.
- Reset values:
  - all regs = 0
  - alu_in0 = alu_in1 = 0, alu_select = 0
  - ex_valid = 0
  - wb_valid = 0, wb_rd = 0, wb_data = 0
  - instr_ready = 0 during the reset cycle
- Register file: r0 hardwired to 0. Reads of r0 return 0; writes to r0 are discarded, but wb_valid still pulses with wb_data = the ALU value.
- Issue: occurs when instr_valid && instr_ready at a rising edge (edge N). At edge N the stage latches:
  - alu_in0 <= operand A
  - alu_in1 <= operand B or instr_imm
  - alu_select <= instr_sel, ex_rd <= instr_rd, ex_valid <= 1
- No issue: ex_valid <= 0; alu_in0/alu_in1/alu_select hold their values.
- Execute/writeback: at edge N+1, if ex_valid:
  - regs[ex_rd] <= alu_out (unless ex_rd = 0)
  - wb_valid <= 1, wb_rd <= ex_rd, wb_data <= alu_out
- Otherwise at edge N+1: wb_valid <= 0, wb_rd/wb_data hold.
- Latency: issue to register-file update is 2 edges. wb_valid is high in the cycle after edge N+1. Throughput is 1 instruction/cycle absent hazards.
- Hazard: an issuing instruction reads ex_rd (nonzero) while ex_valid = 1. Handling is set by ALU_FWD_EN (see Optional Feature).
- Simultaneous write and debug read of the same register: dbg_data shows the old value until the edge.
- Op codes are not interpreted. sel >= 11 passes through; the ALU yields 0, and 0 is written back.
- Division by zero: whatever the ALU returns is written back; no flag.
- Reset mid-operation: an in-flight ex_valid instruction is dropped. No writeback and no wb_valid pulse after reset.

Optional Feature:
Macro ALU_FWD_EN.
- Defined: bypass path. A hazarded source operand takes alu_out instead of the stale register. instr_ready = 1 whenever out of reset; no stalls.
- Undefined: interlock. instr_ready = 0 in any cycle where ex_valid && ex_rd != 0 && (ex_rd == instr_rs1 || (!instr_use_imm && ex_rd == instr_rs2)). The instruction issues the following cycle, after writeback, reading the updated register. Back-to-back dependent instructions therefore cost 1 bubble cycle.

Test Plan:
- Reset with rst_n = 0 for 2 cycles -> all outputs 0; dbg_data = 0 for addresses 0..7; instr_ready = 0 while in reset.
- Load immediates:
  - r1 <- imm 13 (sel=1, use_imm)
  - r2 <- imm 6
  - r3 <- r1 + r2 (sel=2)
  - Response: wb_data sequence 13, 6, 19; dbg_data(r3) = 19.
- r0 write: rd=0, sel=1, imm 0xBEEF -> wb_valid pulses with wb_data = 0xBEEF; dbg_data(r0) = 0.
- Dependent back-to-back: r4 <- r1 - r2 (sel=3) then r5 <- r4 * r2 (sel=4).
  - ALU_FWD_EN defined: no stall; r5 = 42.
  - ALU_FWD_EN undefined: instr_ready low for exactly 1 cycle; r5 = 42.
- Unused op: sel=11, rd=6 -> alu_select = 11, r6 = 0, wb_valid pulses.
- Reset mid-op: issue r7 <- imm 0x1234, then assert rst_n = 0 at the next edge -> no wb_valid; dbg_data(r7) = 0 after reset.
